// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - two-digit seven-segment readback with settle filter and BCD decode
//
// Purpose: samples the tens and ones segment buses, waits until the pair has
// been unchanged for STABLE_CYCLES edges, decodes both digits and publishes
// the BCD digits plus their binary value 0..99.
//
// Ports:
//   i_Clk        system clock
//   i_Reset      synchronous reset, active-high
//   i_Seg_Tens   tens-digit segments, bit0=A .. bit6=G
//   i_Seg_Ones   ones-digit segments, bit0=A .. bit6=G
//   o_Tens       captured tens digit, BCD
//   o_Ones       captured ones digit, BCD
//   o_Value      o_Tens*10 + o_Ones
//   o_Valid      one-cycle pulse when a new value is published
//   o_Error      last stable pattern pair did not decode
//   o_Locked     a stable, decoded value is held
module seven_segment_capture #(
   parameter int STABLE_CYCLES = 250000,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [6:0] i_Seg_Tens,
   input  logic [6:0] i_Seg_Ones,
   output logic [3:0] o_Tens,
   output logic [3:0] o_Ones,
   output logic [6:0] o_Value,
   output logic       o_Valid,
   output logic       o_Error,
   output logic       o_Locked
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [13:0]   samp_q;
   logic [13:0]   samp_in;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic [6:0]    value_q, value_d;
   logic          valid_q, valid_d;
   logic          error_q, error_d;
   logic          locked_q, locked_d;
   // Forces the next valid capture to publish: set after reset and after an
   // undecodable capture, so an unchanged value is still announced.
   logic          fresh_q, fresh_d;

   logic [4:0]    tens_dec;
   logic [4:0]    ones_dec;
   logic [6:0]    new_value;

   // Returns {ok, bcd}; ok=0 for any pattern that is not a digit.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      case (seg)
         7'h3F:   decode_seg = {1'b1, 4'd0};
         7'h06:   decode_seg = {1'b1, 4'd1};
         7'h5B:   decode_seg = {1'b1, 4'd2};
         7'h4F:   decode_seg = {1'b1, 4'd3};
         7'h66:   decode_seg = {1'b1, 4'd4};
         7'h6D:   decode_seg = {1'b1, 4'd5};
         7'h7D:   decode_seg = {1'b1, 4'd6};
         7'h07:   decode_seg = {1'b1, 4'd7};
         7'h7F:   decode_seg = {1'b1, 4'd8};
         7'h6F:   decode_seg = {1'b1, 4'd9};
         default: decode_seg = 5'b0;
      endcase
   endfunction

   // Everything downstream works in lit=1 terms.
   assign samp_in = ACTIVE_LOW ? ~{i_Seg_Tens, i_Seg_Ones} : {i_Seg_Tens, i_Seg_Ones};

   // A blank tens digit is leading-zero suppression, so it reads as 0.
   assign tens_dec = (samp_q[13:7] == 7'h00) ? {1'b1, 4'd0} : decode_seg(samp_q[13:7]);
   assign ones_dec = decode_seg(samp_q[6:0]);

   // x*10 = x*8 + x*2
   assign new_value = {tens_dec[3:0], 3'b000} + {2'b00, tens_dec[3:0], 1'b0} + {3'b000, ones_dec[3:0]};

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         samp_q   <= '0;
         tens_q   <= '0;
         ones_q   <= '0;
         value_q  <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         locked_q <= 1'b0;
         fresh_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         samp_q   <= samp_in;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         value_q  <= value_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
         locked_q <= locked_d;
         fresh_q  <= fresh_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      value_d  = value_q;
      valid_d  = 1'b0;
      error_d  = error_q;
      locked_d = locked_q;
      fresh_d  = fresh_q;

      if (samp_in != samp_q) begin
         // Any change, from any state, restarts settling; outputs hold.
         state_d = SETTLE;
         cnt_d   = '0;
      end else if (state_q == SETTLE) begin
         if (cnt_q == CNT_LAST) begin
            state_d = LOCKED;
            cnt_d   = '0;
            if (tens_dec[4] && ones_dec[4]) begin
               tens_d   = tens_dec[3:0];
               ones_d   = ones_dec[3:0];
               value_d  = new_value;
               error_d  = 1'b0;
               locked_d = 1'b1;
               valid_d  = fresh_q || (new_value != value_q);
               fresh_d  = 1'b0;
            end else begin
               error_d  = 1'b1;
               locked_d = 1'b0;
               fresh_d  = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign o_Tens   = tens_q;
   assign o_Ones   = ones_q;
   assign o_Value  = value_q;
   assign o_Valid  = valid_q;
   assign o_Error  = error_q;
   assign o_Locked = locked_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb/tb_seven_segment_capture.sv - directed scoreboard bench for seven_segment_capture
module tb_seven_segment_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_tens;
   logic [6:0] seg_ones;
   logic [3:0] o_tens;
   logic [3:0] o_ones;
   logic [6:0] o_value;
   logic       o_valid;
   logic       o_error;
   logic       o_locked;

   int checks   = 0;
   int failures = 0;
   int valid_cnt = 0;

   typedef struct {
      logic [3:0] t;
      logic [3:0] o;
      logic [6:0] v;
   } exp_t;

   exp_t sb[$];

   seven_segment_capture #(
      .STABLE_CYCLES(4),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .i_Clk     (clk),
      .i_Reset   (rst),
      .i_Seg_Tens(seg_tens),
      .i_Seg_Ones(seg_ones),
      .o_Tens    (o_tens),
      .o_Ones    (o_ones),
      .o_Value   (o_value),
      .o_Valid   (o_valid),
      .o_Error   (o_error),
      .o_Locked  (o_locked)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_valid) valid_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Patterns given in lit=1 terms; the board pins are active-low.
   task automatic drive(input logic [6:0] t, input logic [6:0] o);
      seg_tens = ~t;
      seg_ones = ~o;
   endtask

   task automatic push(input logic [3:0] t, input logic [3:0] o, input logic [6:0] v);
      exp_t e;
      e.t = t;
      e.o = o;
      e.v = v;
      sb.push_back(e);
   endtask

   task automatic wait_valid(input string tag, output int cyc);
      cyc = 0;
      for (int n = 1; n <= 50; n++) begin
         tick();
         if (o_valid) begin
            cyc = n;
            break;
         end
      end
      if (cyc == 0) chk({tag, "_timeout"}, 32'(0), 32'(1));
   endtask

   task automatic check_pop(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(0), 32'(1));
      end else begin
         e = sb.pop_front();
         chk({tag, "_tens"},  32'(o_tens),  32'(e.t));
         chk({tag, "_ones"},  32'(o_ones),  32'(e.o));
         chk({tag, "_value"}, 32'(o_value), 32'(e.v));
      end
      // The pulse must last exactly one cycle.
      tick();
      chk({tag, "_valid_width"}, 32'(o_valid), 32'(0));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tens"},   32'(o_tens),   32'(0));
      chk({tag, "_ones"},   32'(o_ones),   32'(0));
      chk({tag, "_value"},  32'(o_value),  32'(0));
      chk({tag, "_valid"},  32'(o_valid),  32'(0));
      chk({tag, "_error"},  32'(o_error),  32'(0));
      chk({tag, "_locked"}, 32'(o_locked), 32'(0));
   endtask

   initial begin
      int cyc;
      int v0;

      rst = 1'b1;
      drive(7'h00, 7'h00);
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;

      // All-dark display after reset: nothing published.
      repeat (10) tick();
      chk("dark_no_valid", 32'(valid_cnt), 32'(0));
      chk("dark_unlocked", 32'(o_locked), 32'(0));

      // 1. "01"
      drive(7'h3F, 7'h06);
      push(4'd0, 4'd1, 7'd1);
      wait_valid("t1", cyc);
      chk("t1_latency", 32'(cyc), 32'(5));
      chk("t1_locked", 32'(o_locked), 32'(1));
      chk("t1_error", 32'(o_error), 32'(0));
      check_pop("t1");

      // 2. "39", then a long hold
      drive(7'h4F, 7'h6F);
      push(4'd3, 4'd9, 7'd39);
      wait_valid("t2", cyc);
      chk("t2_latency", 32'(cyc), 32'(5));
      check_pop("t2");
      v0 = valid_cnt;
      repeat (100) tick();
      chk("t2_hold_no_valid", 32'(valid_cnt), 32'(v0));

      // 3. Two-cycle glitch on the ones digit, then back to "39"
      v0 = valid_cnt;
      drive(7'h4F, 7'h7F);
      repeat (2) begin
         tick();
         chk("t3_value_glitch", 32'(o_value), 32'(39));
      end
      drive(7'h4F, 7'h6F);
      repeat (12) begin
         tick();
         chk("t3_value_hold", 32'(o_value), 32'(39));
      end
      chk("t3_no_valid", 32'(valid_cnt), 32'(v0));
      chk("t3_locked", 32'(o_locked), 32'(1));

      // 4. " 2", then invalid, then "02" with the same value
      drive(7'h00, 7'h5B);
      push(4'd0, 4'd2, 7'd2);
      wait_valid("t4a", cyc);
      check_pop("t4a");
      v0 = valid_cnt;
      drive(7'h00, 7'h00);
      repeat (8) tick();
      chk("t4b_error", 32'(o_error), 32'(1));
      chk("t4b_locked", 32'(o_locked), 32'(0));
      chk("t4b_value", 32'(o_value), 32'(2));
      chk("t4b_no_valid", 32'(valid_cnt), 32'(v0));
      drive(7'h3F, 7'h5B);
      push(4'd0, 4'd2, 7'd2);
      wait_valid("t4c", cyc);
      chk("t4c_error", 32'(o_error), 32'(0));
      chk("t4c_locked", 32'(o_locked), 32'(1));
      check_pop("t4c");

      // 5. "99" interrupted by reset, then captured afresh
      drive(7'h6F, 7'h6F);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check_zero("t5_reset");
      v0 = valid_cnt;
      repeat (3) tick();
      chk("t5_reset_no_valid", 32'(valid_cnt), 32'(v0));
      rst = 1'b0;
      push(4'd9, 4'd9, 7'd99);
      wait_valid("t5", cyc);
      chk("t5_latency", 32'(cyc), 32'(5));
      chk("t5_locked", 32'(o_locked), 32'(1));
      check_pop("t5");

      chk("sb_drained", 32'(sb.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
